// File: rtl/pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_skid
// Purpose  : Valid/ready pipeline stage with a 2-entry skid buffer. in_ready
//            depends only on registered state and reset, so ready never
//            ripples combinationally back through a chain of stages.
//            Selectable flush behaviour (discard or bubble insertion) and an
//            occupancy output. All state updates on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_skid #(
  parameter int                    PIPE_WIDTH = 32,
  parameter int                    FLUSH_MODE = 1,
  parameter logic [PIPE_WIDTH-1:0] RESET_DATA = {PIPE_WIDTH{1'b0}}
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [PIPE_WIDTH-1:0] flush_input,
  input  logic                  in_valid,
  input  logic [PIPE_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [PIPE_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [1:0]            occupancy
);

  // Bubble mode reloads the main entry with the NOP word on flush.
  localparam logic c_FLUSH_BUBBLE = (FLUSH_MODE != 0);

  // Main entry feeds the output; skid entry only ever holds the beat that
  // arrived while main was stalled, so skid valid implies main valid.
  logic [PIPE_WIDTH-1:0] main_data_q, main_data_d;
  logic                  main_v_q,    main_v_d;
  logic [PIPE_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  skid_v_q,    skid_v_d;

  logic w_accept;
  logic w_emit;

  assign in_ready  = ~skid_v_q & ~reset;
  assign out_valid = main_v_q;
  assign out_data  = main_data_q;
  assign occupancy = {1'b0, main_v_q} + {1'b0, skid_v_q};

  assign w_accept = in_valid & in_ready;
  assign w_emit   = main_v_q & out_ready;

  // Next-state selection: reset beats flush, flush beats normal traffic.
  always_comb begin
    main_data_d = main_data_q;
    main_v_d    = main_v_q;
    skid_data_d = skid_data_q;
    skid_v_d    = skid_v_q;

    if (reset) begin
      main_data_d = RESET_DATA;
      main_v_d    = 1'b0;
      skid_data_d = RESET_DATA;
      skid_v_d    = 1'b0;
    end else if (flush) begin
      // Any beat accepted this cycle is dropped; an emit still completes
      // downstream because the consumer already sampled out_data.
      skid_v_d = 1'b0;
      if (c_FLUSH_BUBBLE) begin
        main_data_d = flush_input;
        main_v_d    = 1'b1;
      end else begin
        main_v_d    = 1'b0;
      end
    end else if (!main_v_q) begin
      // Empty stage: a new beat goes straight into the main entry.
      if (w_accept) begin
        main_data_d = in_data;
        main_v_d    = 1'b1;
      end
    end else if (!skid_v_q) begin
      // One beat held: either it leaves (refill from input) or the new
      // beat parks in the skid entry.
      if (w_emit) begin
        if (w_accept) begin
          main_data_d = in_data;
        end else begin
          main_v_d = 1'b0;
        end
      end else if (w_accept) begin
        skid_data_d = in_data;
        skid_v_d    = 1'b1;
      end
    end else begin
      // Both entries full: in_ready is low, so only draining is possible.
      if (w_emit) begin
        main_data_d = skid_data_q;
        skid_v_d    = 1'b0;
      end
    end
  end

  // Stage state register, updated on the falling edge.
  always_ff @(negedge clock) begin
    main_data_q <= main_data_d;
    main_v_q    <= main_v_d;
    skid_data_q <= skid_data_d;
    skid_v_q    <= skid_v_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_skid
// Purpose  : Self-checking bench for pipe_stage_skid. Two instances share the
//            stimulus: one in bubble flush mode, one in discard flush mode.
//            A queue-based reference model tracks each instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;

  logic        clock;
  logic        reset;
  logic        flush;
  logic [31:0] flush_input;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  logic        in_ready_b,  out_valid_b;
  logic [31:0] out_data_b;
  logic [1:0]  occ_b;
  logic        in_ready_d,  out_valid_d;
  logic [31:0] out_data_d;
  logic [1:0]  occ_d;

  int tests = 0;
  int fails = 0;

  pipe_stage_skid #(.PIPE_WIDTH(32), .FLUSH_MODE(1)) dut_b (
    .clock(clock), .reset(reset), .flush(flush), .flush_input(flush_input),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_data(out_data_b), .out_ready(out_ready),
    .occupancy(occ_b)
  );

  pipe_stage_skid #(.PIPE_WIDTH(32), .FLUSH_MODE(0)) dut_d (
    .clock(clock), .reset(reset), .flush(flush), .flush_input(flush_input),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_d),
    .out_valid(out_valid_d), .out_data(out_data_d), .out_ready(out_ready),
    .occupancy(occ_d)
  );

  initial clock = 1'b1;
  always #5 clock = ~clock;

  // ---------------- reference model: FIFO of at most two beats -------------
  logic [31:0] qb[$];
  logic [31:0] qd[$];
  logic [31:0] lastb = '0;
  logic [31:0] lastd = '0;

  task automatic model_step(input bit bubble);
    logic [31:0] q[$];
    logic [31:0] last;
    bit acc, em;
    if (bubble) begin q = qb; last = lastb; end
    else        begin q = qd; last = lastd; end
    if (reset) begin
      q.delete();
      last = '0;
    end else begin
      acc = in_valid && (q.size() < 2);
      em  = (q.size() > 0) && out_ready;
      if (flush) begin
        q.delete();
        if (bubble) q.push_back(flush_input);
      end else begin
        if (em)  void'(q.pop_front());
        if (acc) q.push_back(in_data);
      end
      // The output register keeps its last word when the stage empties.
      if (q.size() > 0) last = q[0];
    end
    if (bubble) begin qb = q; lastb = last; end
    else        begin qd = q; lastd = last; end
  endtask

  always @(negedge clock) begin
    model_step(1'b1);
    model_step(1'b0);
  end

  // Advance to just after the next active (falling) edge.
  task automatic tick;
    @(negedge clock);
    #2;
  endtask

  task automatic idle_inputs;
    flush = 0; flush_input = '0; in_valid = 0; in_data = '0; out_ready = 0;
  endtask

  // ---------------- directed scenarios ----------------
  task automatic test_reset;
    idle_inputs();
    reset = 1;
    tick(); tick();
    tests++; if (out_valid_b !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", out_valid_b); end
    tests++; if (occ_b !== 2'd0) begin fails++; $display("FAIL reset_occ got=%0d exp=0", occ_b); end
    tests++; if (out_data_b !== 32'h0) begin fails++; $display("FAIL reset_data got=%h exp=0", out_data_b); end
    tests++; if (in_ready_b !== 1'b0) begin fails++; $display("FAIL reset_inready got=%b exp=0", in_ready_b); end
    // Beat offered during reset must be ignored.
    in_valid = 1; in_data = 32'hDEAD;
    tick();
    tests++; if (occ_d !== 2'd0) begin fails++; $display("FAIL reset_ignore_beat occ got=%0d exp=0", occ_d); end
    in_valid = 0;
    reset = 0;
    #1;
    tests++; if (in_ready_b !== 1'b1) begin fails++; $display("FAIL reset_release_inready got=%b exp=1", in_ready_b); end
  endtask

  task automatic test_streaming;
    logic [31:0] v;
    out_ready = 1;
    in_valid  = 1;
    for (int i = 1; i <= 4; i++) begin
      v = i;
      in_data = v;
      tick();
      tests++; if (out_data_b !== v || out_valid_b !== 1'b1) begin fails++; $display("FAIL stream_data beat=%0d got=%h/%b exp=%h/1", i, out_data_b, out_valid_b, v); end
      tests++; if (occ_d !== 2'd1 || in_ready_d !== 1'b1) begin fails++; $display("FAIL stream_occ beat=%0d got occ=%0d rdy=%b exp occ=1 rdy=1", i, occ_d, in_ready_d); end
    end
    in_valid = 0;
    tick();
    tests++; if (out_valid_b !== 1'b0 || occ_b !== 2'd0) begin fails++; $display("FAIL stream_drain got valid=%b occ=%0d exp 0/0", out_valid_b, occ_b); end
  endtask

  task automatic test_backpressure;
    out_ready = 0;
    in_valid = 1; in_data = 32'hA; tick();
    in_data = 32'hB; tick();
    tests++; if (occ_b !== 2'd2 || in_ready_b !== 1'b0) begin fails++; $display("FAIL bp_full got occ=%0d rdy=%b exp 2/0", occ_b, in_ready_b); end
    tests++; if (out_data_b !== 32'hA) begin fails++; $display("FAIL bp_hold got=%h exp=a", out_data_b); end
    in_data = 32'hC; tick();
    tests++; if (occ_b !== 2'd2 || out_data_b !== 32'hA) begin fails++; $display("FAIL bp_reject got occ=%0d data=%h exp 2/a", occ_b, out_data_b); end
    in_valid = 0; out_ready = 1; tick();
    tests++; if (out_data_b !== 32'hB || occ_b !== 2'd1 || in_ready_b !== 1'b1) begin fails++; $display("FAIL bp_drain1 got data=%h occ=%0d rdy=%b exp b/1/1", out_data_b, occ_b, in_ready_b); end
    in_valid = 1; in_data = 32'hC; tick();
    tests++; if (out_data_b !== 32'hC || occ_b !== 2'd1) begin fails++; $display("FAIL bp_represent got data=%h occ=%0d exp c/1", out_data_b, occ_b); end
    in_valid = 0; tick();
    tests++; if (out_valid_b !== 1'b0 || occ_b !== 2'd0) begin fails++; $display("FAIL bp_empty got valid=%b occ=%0d exp 0/0", out_valid_b, occ_b); end
  endtask

  task automatic fill_11_22;
    out_ready = 0;
    in_valid = 1; in_data = 32'h11; tick();
    in_data = 32'h22; tick();
    in_valid = 0;
  endtask

  task automatic test_flush_bubble;
    fill_11_22();
    flush = 1; flush_input = 32'hE1A0_0000; tick();
    flush = 0;
    tests++; if (out_valid_b !== 1'b1 || out_data_b !== 32'hE1A0_0000 || occ_b !== 2'd1) begin fails++; $display("FAIL flush_bubble got valid=%b data=%h occ=%0d exp 1/e1a00000/1", out_valid_b, out_data_b, occ_b); end
    out_ready = 1; tick();
    tests++; if (out_valid_b !== 1'b0 || out_data_b === 32'h22) begin fails++; $display("FAIL flush_bubble_no22 got valid=%b data=%h exp valid=0 data!=22", out_valid_b, out_data_b); end
    out_ready = 0;
  endtask

  task automatic test_flush_discard;
    fill_11_22();
    flush = 1; flush_input = 32'hE1A0_0000; in_valid = 1; in_data = 32'h33; tick();
    flush = 0; in_valid = 0;
    tests++; if (out_valid_d !== 1'b0 || occ_d !== 2'd0) begin fails++; $display("FAIL flush_discard got valid=%b occ=%0d exp 0/0", out_valid_d, occ_d); end
    tests++; if (occ_b !== 2'd1 || out_data_b !== 32'hE1A0_0000) begin fails++; $display("FAIL flush_drop33_bubble got occ=%0d data=%h exp 1/e1a00000", occ_b, out_data_b); end
    out_ready = 1; tick();
    tests++; if (out_valid_d !== 1'b0 || occ_d !== 2'd0 || out_valid_b !== 1'b0) begin fails++; $display("FAIL flush_drop33 got valid_d=%b occ_d=%0d valid_b=%b exp 0/0/0", out_valid_d, occ_d, out_valid_b); end
    out_ready = 0;
  endtask

  task automatic test_reset_stall;
    fill_11_22();
    tests++; if (occ_d !== 2'd2) begin fails++; $display("FAIL rst_stall_pre got occ=%0d exp 2", occ_d); end
    reset = 1; tick();
    tests++; if (out_valid_d !== 1'b0 || out_data_d !== 32'h0 || occ_d !== 2'd0 || in_ready_d !== 1'b0) begin fails++; $display("FAIL rst_stall got valid=%b data=%h occ=%0d rdy=%b exp 0/0/0/0", out_valid_d, out_data_d, occ_d, in_ready_d); end
    reset = 0; #1;
    tests++; if (in_ready_d !== 1'b1) begin fails++; $display("FAIL rst_stall_release got rdy=%b exp 1", in_ready_d); end
  endtask

  // ---------------- random soak against the reference model ----------------
  task automatic test_random_soak;
    bit stall_b, stall_d;
    logic [31:0] prev_b, prev_d;
    bit ev, er;
    reset = 1; tick(); reset = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset       = ($urandom_range(0, 99) < 2);
      flush       = ($urandom_range(0, 99) < 5);
      in_valid    = ($urandom_range(0, 99) < 65);
      out_ready   = ($urandom_range(0, 99) < 55);
      in_data     = $urandom;
      flush_input = $urandom;
      stall_b = out_valid_b && !out_ready && !flush && !reset;
      stall_d = out_valid_d && !out_ready && !flush && !reset;
      prev_b  = out_data_b;
      prev_d  = out_data_d;
      tick();
      // bubble-mode instance
      ev = (qb.size() > 0);
      er = (qb.size() < 2) && !reset;
      tests++; if (out_valid_b !== ev) begin fails++; $display("FAIL soak_b_valid cyc=%0d got=%b exp=%b", cyc, out_valid_b, ev); end
      tests++; if (occ_b !== 2'(qb.size())) begin fails++; $display("FAIL soak_b_occ cyc=%0d got=%0d exp=%0d", cyc, occ_b, qb.size()); end
      tests++; if (out_data_b !== lastb) begin fails++; $display("FAIL soak_b_data cyc=%0d got=%h exp=%h", cyc, out_data_b, lastb); end
      tests++; if (in_ready_b !== er) begin fails++; $display("FAIL soak_b_ready cyc=%0d got=%b exp=%b", cyc, in_ready_b, er); end
      tests++; if ((occ_b != 2'd0) !== out_valid_b) begin fails++; $display("FAIL soak_b_illegal cyc=%0d occ=%0d valid=%b", cyc, occ_b, out_valid_b); end
      if (stall_b) begin
        tests++; if (out_data_b !== prev_b) begin fails++; $display("FAIL soak_b_stable cyc=%0d got=%h exp=%h", cyc, out_data_b, prev_b); end
      end
      // discard-mode instance
      ev = (qd.size() > 0);
      er = (qd.size() < 2) && !reset;
      tests++; if (out_valid_d !== ev) begin fails++; $display("FAIL soak_d_valid cyc=%0d got=%b exp=%b", cyc, out_valid_d, ev); end
      tests++; if (occ_d !== 2'(qd.size())) begin fails++; $display("FAIL soak_d_occ cyc=%0d got=%0d exp=%0d", cyc, occ_d, qd.size()); end
      tests++; if (out_data_d !== lastd) begin fails++; $display("FAIL soak_d_data cyc=%0d got=%h exp=%h", cyc, out_data_d, lastd); end
      tests++; if (in_ready_d !== er) begin fails++; $display("FAIL soak_d_ready cyc=%0d got=%b exp=%b", cyc, in_ready_d, er); end
      tests++; if ((occ_d != 2'd0) !== out_valid_d) begin fails++; $display("FAIL soak_d_illegal cyc=%0d occ=%0d valid=%b", cyc, occ_d, out_valid_d); end
      if (stall_d) begin
        tests++; if (out_data_d !== prev_d) begin fails++; $display("FAIL soak_d_stable cyc=%0d got=%h exp=%h", cyc, out_data_d, prev_d); end
      end
    end
    reset = 0; flush = 0; in_valid = 0;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    #2;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush_bubble();
    reset = 1; tick(); reset = 0;
    test_flush_discard();
    reset = 1; tick(); reset = 0;
    test_reset_stall();
    test_random_soak();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised pipeline stage for the core datapath. Carries PIPE_WIDTH bits per beat.
- Successor to the plain flush/reset pipeline register. Adds a valid/ready handshake, a 2-entry skid buffer so in_ready is a registered term, selectable flush mode, and an occupancy output.
- Sits between any two core pipeline stages, so each stage can stall independently without a combinational ready chain.

Parameters:
- PIPE_WIDTH, 32, data width per beat.
- FLUSH_MODE, 1, flush behaviour. 0 = discard: both entries are invalidated. 1 = bubble: the main entry is loaded with flush_input and marked valid, and the skid entry is invalidated.
- RESET_DATA, {PIPE_WIDTH{1'b0}}, value loaded into both data registers on reset.

Ports:
- clock  in  1  stage clock; all state updates on the falling edge.
- reset  in  1  reset, synchronous, active-high.
- flush  in  1  flush request, sampled on the falling edge.
- flush_input  in  PIPE_WIDTH  bubble/NOP word, used when FLUSH_MODE=1.
- in_valid  in  1  upstream beat valid.
- in_data  in  PIPE_WIDTH  upstream beat.
- in_ready  out  1  stage can accept a beat.
- out_valid  out  1  out_data valid.
- out_data  out  PIPE_WIDTH  main-entry data.
- out_ready  in  1  downstream accepts.
- occupancy  out  2  number of valid entries, 0..2.

Behaviour:
- State: main entry (main_data, main_v) and skid entry (skid_data, skid_v). Every update happens on the negedge of clock.
- out_data = main_data, out_valid = main_v, both driven straight from flops.
- in_ready = ~skid_v & ~reset. No combinational path from out_ready to in_ready.
- occupancy = main_v + skid_v. The state skid_v=1 with main_v=0 is illegal and must never occur.
- Accept = in_valid & in_ready. Emit = out_valid & out_ready.
- Priority is reset > flush > normal.
- Reset:
  - main_v = 0, skid_v = 0, both data registers = RESET_DATA.
  - Beats presented during reset are ignored; in_ready=0 while reset is high.
  - A reset arriving mid-stall drops both entries.
- Flush, FLUSH_MODE=0: main_v = 0, skid_v = 0; data registers hold their value.
- Flush, FLUSH_MODE=1: main_data = flush_input, main_v = 1, skid_v = 0.
- Flush, both modes:
  - A beat accepted in the flush cycle is dropped, even though in_ready was high.
  - An emit in the flush cycle still counts as consumed by downstream.
- Normal operation, by case:
  - main empty, accept: main <= in_data, main_v = 1.
  - main empty, no accept: no change.
  - main full, emit, skid empty: main <= in_data if accept, else main_v = 0.
  - main full, no emit, accept: skid <= in_data, skid_v = 1 (in_ready drops next cycle).
  - main full, no emit, no accept: hold.
  - skid full, emit: main <= skid_data, skid_v = 0. No accept is possible in this state.
  - skid full, no emit: hold everything.
- Latency: 1 falling edge from accept to out_valid when the stage is empty. Throughput is 1 beat/cycle when out_ready is held high.
- Ordering: beats leave in strict accept order; no beat is duplicated or lost except by flush or reset.
- Data registers may be written only when the corresponding valid is set, or on reset/flush (for power).
- Stable hold: while out_valid=1 & out_ready=0, out_data must not change.

Test Plan:
- Streaming: reset, then in_valid=1 with in_data=1,2,3,4 on consecutive edges, out_ready=1 → out_data 1,2,3,4 one edge later each; occupancy stays 1; in_ready stays 1.
- Backpressure: out_ready=0, push 0xA then 0xB → occupancy 2, in_ready=0, out_data holds 0xA; push of 0xC is not accepted. Then out_ready=1 → outputs 0xA, 0xB, then 0xC after re-presentation; no loss, order kept.
- Flush, bubble mode (FLUSH_MODE=1): stage holds 0x11/0x22 stalled; flush=1, flush_input=0xE1A0_0000 → next edge out_valid=1, out_data=0xE1A00000, occupancy=1; 0x22 never appears at the output.
- Flush, discard mode (FLUSH_MODE=0): same setup plus in_valid=1, in_data=0x33 in the flush cycle → out_valid=0, occupancy=0; 0x33 dropped.
- Reset during stall: occupancy=2, assert reset for one edge → out_valid=0, out_data=0, occupancy=0, in_ready=0 during reset and 1 after release.
- Random soak: random in_valid/out_ready and 5% flush, compared against a reference queue model → no illegal skid_v-without-main_v state, and out_data stable whenever stalled.
